// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, condition codes, NZCV bit positions and the
// writeback stage FSM state type.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_MOVN = 4'b0110;
  localparam logic [3:0] OP_MOV  = 4'b0111;
  localparam logic [3:0] OP_LSR  = 4'b1000;
  localparam logic [3:0] OP_LSL  = 4'b1001;
  localparam logic [3:0] OP_ROR  = 4'b1010;
  localparam logic [3:0] OP_ADR  = 4'b1011;
  localparam logic [3:0] OP_CMP  = 4'b1100;
  localparam logic [3:0] OP_LDR  = 4'b1101;
  localparam logic [3:0] OP_STR  = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam logic [3:0] COND_AL = 4'b0000;
  localparam logic [3:0] COND_EQ = 4'b0001;
  localparam logic [3:0] COND_NE = 4'b0010;
  localparam logic [3:0] COND_MI = 4'b0011;
  localparam logic [3:0] COND_PL = 4'b0100;
  localparam logic [3:0] COND_CS = 4'b0101;
  localparam logic [3:0] COND_CC = 4'b0110;
  localparam logic [3:0] COND_VS = 4'b0111;
  localparam logic [3:0] COND_VC = 4'b1000;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM_RD = 2'd1,
    MEM_WR = 2'd2
  } wb_state_e;

  // Opcodes that write their ALU result straight to the register file.
  function automatic logic is_alu_write(logic [3:0] op);
    return (op <= OP_ADR);
  endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code evaluator against an NZCV flag vector.
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] flags_i,
  input  logic [3:0] cond_i,
  output logic       pass_o
);

  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_AL: pass_o = 1'b1;
      COND_EQ: pass_o = flags_i[FLAG_Z];
      COND_NE: pass_o = ~flags_i[FLAG_Z];
      COND_MI: pass_o = flags_i[FLAG_N];
      COND_PL: pass_o = ~flags_i[FLAG_N];
      COND_CS: pass_o = flags_i[FLAG_C];
      COND_CC: pass_o = ~flags_i[FLAG_C];
      COND_VS: pass_o = flags_i[FLAG_V];
      COND_VC: pass_o = ~flags_i[FLAG_V];
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// Retire stage after the ALU: owns NZCV, commits register writes and sequences
// single-outstanding LDR/STR memory requests.
module alu_writeback_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RF_AW  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [3:0]        in_new_flag,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_cond,
  input  logic              in_s,
  input  logic [RF_AW-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_store_data,
  output logic [3:0]        flag_out,
  output logic              rf_we,
  output logic [RF_AW-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       retire_count
);

  wb_state_e         state_q, state_d;
  logic [3:0]        flag_q, flag_d;
  logic              rf_we_q, rf_we_d;
  logic [RF_AW-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [RF_AW-1:0]  ld_rd_q, ld_rd_d;
  logic [31:0]       retire_count_q, retire_count_d;
  logic              cond_pass;
  logic              accept;

  cond_check u_cond_check (
    .flags_i (flag_q),
    .cond_i  (in_cond),
    .pass_o  (cond_pass)
  );

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d        = state_q;
    flag_d         = flag_q;
    rf_we_d        = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    ld_rd_d        = ld_rd_q;
    retire_count_d = retire_count_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          retire_count_d = retire_count_q + 32'd1;
          if (cond_pass) begin
            if (is_alu_write(in_opcode)) begin
              rf_we_d    = 1'b1;
              rf_waddr_d = in_rd;
              rf_wdata_d = in_result;
              if (in_s) flag_d = in_new_flag;
            end else if (in_opcode == OP_CMP) begin
              flag_d = in_new_flag;
            end else if (in_opcode == OP_LDR) begin
              state_d    = MEM_RD;
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = in_result;
              ld_rd_d    = in_rd;
            end else if (in_opcode == OP_STR) begin
              state_d     = MEM_WR;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = in_result;
              mem_wdata_d = in_store_data;
            end
          end
        end
      end
      MEM_RD: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          rf_we_d    = 1'b1;
          rf_waddr_d = ld_rd_q;
          rf_wdata_d = mem_rdata;
        end
      end
      MEM_WR: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      flag_q         <= '0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      ld_rd_q        <= '0;
      retire_count_q <= '0;
    end else begin
      state_q        <= state_d;
      flag_q         <= flag_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      ld_rd_q        <= ld_rd_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign flag_out     = flag_q;
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_alu_writeback_stage;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [3:0]  in_new_flag;
  logic [3:0]  in_opcode;
  logic [3:0]  in_cond;
  logic        in_s;
  logic [3:0]  in_rd;
  logic [31:0] in_store_data;
  logic [3:0]  flag_out;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] retire_count;

  int tests = 0;
  int fails = 0;

  alu_writeback_stage #(.DATA_W(32), .RF_AW(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_result     (in_result),
    .in_new_flag   (in_new_flag),
    .in_opcode     (in_opcode),
    .in_cond       (in_cond),
    .in_s          (in_s),
    .in_rd         (in_rd),
    .in_store_data (in_store_data),
    .flag_out      (flag_out),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .retire_count  (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state tracked per accepted bundle.
  function automatic logic cond_ok(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0: return 1'b1;
      4'd1: return z;
      4'd2: return !z;
      4'd3: return n;
      4'd4: return !n;
      4'd5: return cf;
      4'd6: return !cf;
      4'd7: return v;
      4'd8: return !v;
      default: return 1'b0;
    endcase
  endfunction

  logic        m_busy, m_load, m_rf_we;
  logic [3:0]  m_flags, m_rd, m_rf_waddr;
  logic [31:0] m_count, m_addr, m_wdata, m_rf_wdata;
  logic [31:0] count_offset = 32'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_load <= 1'b0; m_rf_we <= 1'b0;
      m_flags <= 4'd0; m_rd <= 4'd0; m_rf_waddr <= 4'd0;
      m_count <= 32'd0; m_addr <= 32'd0; m_wdata <= 32'd0; m_rf_wdata <= 32'd0;
    end else begin
      m_rf_we <= 1'b0;
      if (!m_busy) begin
        if (in_valid) begin
          m_count <= m_count + 32'd1;
          if (cond_ok(m_flags, in_cond)) begin
            if (in_opcode == OP_CMP) begin
              m_flags <= in_new_flag;
            end else if (in_opcode == OP_LDR) begin
              m_busy <= 1'b1; m_load <= 1'b1; m_addr <= in_result; m_rd <= in_rd;
            end else if (in_opcode == OP_STR) begin
              m_busy <= 1'b1; m_load <= 1'b0; m_addr <= in_result; m_wdata <= in_store_data;
            end else if (in_opcode != OP_NOP) begin
              m_rf_we <= 1'b1; m_rf_waddr <= in_rd; m_rf_wdata <= in_result;
              if (in_s) m_flags <= in_new_flag;
            end
          end
        end
      end else if (mem_ack) begin
        m_busy <= 1'b0;
        if (m_load) begin
          m_rf_we <= 1'b1; m_rf_waddr <= m_rd; m_rf_wdata <= mem_rdata;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
      chk("m_flag_out", {28'd0, flag_out}, {28'd0, m_flags});
      chk("m_rf_we", {31'd0, rf_we}, {31'd0, m_rf_we});
      if (m_rf_we) begin
        chk("m_rf_waddr", {28'd0, rf_waddr}, {28'd0, m_rf_waddr});
        chk("m_rf_wdata", rf_wdata, m_rf_wdata);
      end
      chk("m_mem_req", {31'd0, mem_req}, {31'd0, m_busy});
      if (m_busy) begin
        chk("m_mem_we", {31'd0, mem_we}, {31'd0, !m_load});
        chk("m_mem_addr", mem_addr, m_addr);
        if (!m_load) chk("m_mem_wdata", mem_wdata, m_wdata);
      end
      chk("m_retire_count", retire_count, m_count + count_offset);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one bundle for one cycle; returns 1 time unit after its edge.
  task automatic send(input logic [3:0] op, input logic [3:0] cond, input logic s,
                      input logic [3:0] rd, input logic [31:0] res, input logic [3:0] nf,
                      input logic [31:0] sd);
    in_valid = 1'b1; in_opcode = op; in_cond = cond; in_s = s; in_rd = rd;
    in_result = res; in_new_flag = nf; in_store_data = sd;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_flag_out"}, {28'd0, flag_out}, 32'd0);
    chk({tag, "_rf_we"}, {31'd0, rf_we}, 32'd0);
    chk({tag, "_rf_waddr"}, {28'd0, rf_waddr}, 32'd0);
    chk({tag, "_rf_wdata"}, rf_wdata, 32'd0);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_retire_count"}, retire_count, 32'd0);
  endtask

  logic [15:0] sweep_pass;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_new_flag = '0; in_opcode = OP_NOP;
    in_cond = COND_AL; in_s = 1'b0; in_rd = '0; in_store_data = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #12;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    step();

    // ADD with S: write r3 and set NZCV to 1001.
    send(OP_ADD, COND_AL, 1'b1, 4'd3, 32'h8000_0001, 4'b1001, 32'd0);
    #1;
    chk("add_rf_we", {31'd0, rf_we}, 32'd1);
    chk("add_rf_waddr", {28'd0, rf_waddr}, 32'd3);
    chk("add_rf_wdata", rf_wdata, 32'h8000_0001);
    chk("add_flags", {28'd0, flag_out}, 32'h9);
    chk("add_count", retire_count, 32'd1);

    // CMP sets Z even with S=0; following EQ passes, NE fails.
    send(OP_CMP, COND_AL, 1'b0, 4'd0, 32'd0, 4'b0100, 32'd0);
    #1;
    chk("cmp_rf_we", {31'd0, rf_we}, 32'd0);
    chk("cmp_flags", {28'd0, flag_out}, 32'h4);
    send(OP_SUB, COND_EQ, 1'b0, 4'd5, 32'h0000_1234, 4'b0000, 32'd0);
    #1;
    chk("sub_eq_rf_we", {31'd0, rf_we}, 32'd1);
    chk("sub_eq_rf_wdata", rf_wdata, 32'h0000_1234);
    chk("sub_eq_flags", {28'd0, flag_out}, 32'h4);
    send(OP_SUB, COND_NE, 1'b1, 4'd6, 32'h0000_5678, 4'b1111, 32'd0);
    #1;
    chk("sub_ne_rf_we", {31'd0, rf_we}, 32'd0);
    chk("sub_ne_flags", {28'd0, flag_out}, 32'h4);
    chk("sub_ne_count", retire_count, 32'd4);

    // LDR with ack in the fourth request cycle.
    send(OP_LDR, COND_AL, 1'b0, 4'd7, 32'h0000_0040, 4'b0000, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ldr_in_ready", {31'd0, in_ready}, 32'd0);
      chk("ldr_mem_req", {31'd0, mem_req}, 32'd1);
      chk("ldr_mem_addr", mem_addr, 32'h40);
      chk("ldr_mem_we", {31'd0, mem_we}, 32'd0);
      step();
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    chk("ldr_rf_we", {31'd0, rf_we}, 32'd1);
    chk("ldr_rf_waddr", {28'd0, rf_waddr}, 32'd7);
    chk("ldr_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
    chk("ldr_mem_req_low", {31'd0, mem_req}, 32'd0);
    chk("ldr_in_ready_back", {31'd0, in_ready}, 32'd1);
    chk("ldr_count", retire_count, 32'd5);

    // STR acked on its first request cycle.
    send(OP_STR, COND_AL, 1'b1, 4'd2, 32'h0000_0010, 4'b1111, 32'd5);
    #1;
    chk("str_mem_req", {31'd0, mem_req}, 32'd1);
    chk("str_mem_we", {31'd0, mem_we}, 32'd1);
    chk("str_mem_wdata", mem_wdata, 32'd5);
    chk("str_mem_addr", mem_addr, 32'h10);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    #1;
    chk("str_mem_req_low", {31'd0, mem_req}, 32'd0);
    chk("str_rf_we", {31'd0, rf_we}, 32'd0);
    chk("str_flags", {28'd0, flag_out}, 32'h4);
    chk("str_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset during MEM_RD, then a stray ack.
    send(OP_LDR, COND_AL, 1'b0, 4'd9, 32'h0000_0080, 4'b0000, 32'd0);
    #1;
    chk("rmid_mem_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rmid");
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      chk("stray_mem_req", {31'd0, mem_req}, 32'd0);
      chk("stray_rf_we", {31'd0, rf_we}, 32'd0);
    end
    mem_ack = 1'b0;
    step();

    // Condition sweep against N=1,Z=0,C=1,V=0, back to back.
    send(OP_CMP, COND_AL, 1'b0, 4'd0, 32'd0, 4'b1010, 32'd0);
    sweep_pass = 16'b0000_0001_0010_1101;
    for (int c = 0; c < 16; c++) begin
      send(OP_ADD, c[3:0], 1'b0, c[3:0], 32'h100 + c, 4'b0001, 32'd0);
      #1;
      chk($sformatf("sweep_cond%0d_rf_we", c), {31'd0, rf_we}, {31'd0, sweep_pass[c]});
      chk($sformatf("sweep_cond%0d_flags", c), {28'd0, flag_out}, 32'hA);
    end
    send(OP_MOV, COND_CS, 1'b1, 4'd1, 32'd0, 4'b0110, 32'd0);
    #1;
    chk("mov_s_flags", {28'd0, flag_out}, 32'h6);
    chk("sweep_count", retire_count, 32'd18);

    // Counter wrap.
    force dut.retire_count_q = 32'hFFFF_FFFF;
    count_offset = 32'hFFFF_FFFF - m_count;
    #1;
    release dut.retire_count_q;
    send(OP_NOP, COND_AL, 1'b1, 4'd4, 32'h55, 4'b1111, 32'd0);
    #1;
    chk("wrap_count", retire_count, 32'd0);
    chk("wrap_rf_we", {31'd0, rf_we}, 32'd0);
    chk("wrap_flags", {28'd0, flag_out}, 32'h6);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_writeback_stage.md
# alu_writeback_stage

Retire stage directly downstream of MASTER_ALU. It accepts each ALU result with a valid/ready handshake and owns the architectural NZCV flag register, whose output feeds the ALU `Flag` input. It evaluates the condition code and commits register-file writes. LDR/STR are sequenced through a single-outstanding memory request handshake.

## Interface
Parameters:
- DATA_W, 32, datapath width; matches ALU `Result`.
- RF_AW, 4, register-file address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  ALU output bundle valid.
- in_ready  out  1  stage can accept a bundle this cycle.
- in_result  in  DATA_W  ALU `Result`; effective address for LDR/STR.
- in_new_flag  in  4  ALU `New_Flag`, [3:0] = {N,Z,C,V}.
- in_opcode  in  4  ALU opcode (0000 ADD … 1111 NOP).
- in_cond  in  4  condition code.
- in_s  in  1  set-flags bit.
- in_rd  in  RF_AW  destination register.
- in_store_data  in  DATA_W  STR data.
- flag_out  out  4  architectural NZCV; drives ALU `Flag`.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  RF_AW  write address.
- rf_wdata  out  DATA_W  write data.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  DATA_W  request address.
- mem_wdata  out  DATA_W  store data.
- mem_ack  in  1  request complete; rdata valid for loads.
- mem_rdata  in  DATA_W  load data.
- retire_count  out  32  count of accepted bundles, including condition-failed ones.

## Operation
- Accept on `in_valid & in_ready`. `in_ready` = 1 only in IDLE.
- Condition is evaluated against `flag_out` at acceptance:
  - 0000 AL
  - 0001 EQ (Z)
  - 0010 NE (!Z)
  - 0011 MI (N)
  - 0100 PL (!N)
  - 0101 CS (C)
  - 0110 CC (!C)
  - 0111 VS (V)
  - 1000 VC (!V)
  - 1001–1111 never.
- A condition-failed bundle is consumed with no register, flag or memory effect. `retire_count` still increments.
- Condition-passed effects by opcode:
  - ADD, SUB, MUL, OR, AND, XOR, MOVn, MOV, LSR, LSL, ROR, ADR: write `in_result` to `in_rd`. Flags update to `in_new_flag` iff `in_s`=1.
  - CMP: flags always update; no register write.
  - LDR: enter MEM_RD. `mem_addr` = `in_result`. On ack, write `mem_rdata` to `in_rd`.
  - STR: enter MEM_WR. `mem_addr` = `in_result`, `mem_wdata` = `in_store_data`. No register write.
  - NOP: no effect.
- FSM:
  - IDLE → MEM_RD / MEM_WR on an accepted, condition-passed LDR / STR.
  - MEM_RD / MEM_WR → IDLE on the cycle `mem_ack`=1.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are held constant while in MEM_RD / MEM_WR.
- `retire_count` wraps 0xFFFFFFFF → 0.

## Timing
- Reset values: `in_ready`=1 (IDLE), `flag_out`=0000, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `retire_count`=0.
- All outputs are registered, except `in_ready`, which is decoded from state.
- `flag_out` takes its new value at the acceptance edge. A bundle accepted on the next cycle sees the updated flags.
- `rf_we` is a one-cycle pulse in the cycle after acceptance (ALU ops), or in the cycle after the `mem_ack` edge (LDR).
- `mem_req` rises in the cycle after acceptance and falls in the cycle after `mem_ack` is sampled high. Minimum LDR/STR occupancy is 2 cycles.
- `mem_ack` is ignored whenever `mem_req`=0.
- Back-to-back ALU ops sustain 1 bundle per cycle.
- Reset mid-transaction: immediate return to IDLE, `mem_req`=0, no `rf_we`. A later stray `mem_ack` is ignored.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants OP_ADD…OP_NOP (0000–1111);
  - condition constants COND_AL…COND_VC;
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - FSM state typedef {IDLE, MEM_RD, MEM_WR}.
- One combinational sub-module, `cond_check` (flags, cond → pass), reused later by branch logic.

## Test plan
- Reset, then ADD: `in_result`=0x80000001, `in_new_flag`=1001, `in_s`=1, `in_rd`=3 → next cycle `rf_we`=1, `rf_waddr`=3, `rf_wdata`=0x80000001; `flag_out`=1001; `retire_count`=1.
- CMP with `in_s`=0 and `in_new_flag`=0100, then SUB with `in_cond`=0001 (EQ) on the next cycle → flags=0100 and SUB writes. Repeat with `in_cond`=0010 (NE) → no `rf_we`, but `retire_count` increments.
- LDR: `in_result`=0x40, `in_rd`=7; `mem_ack` 3 cycles after `mem_req` with `mem_rdata`=0xDEADBEEF → `in_ready`=0 throughout; `mem_addr`=0x40, `mem_we`=0; then `rf_we` with r7=0xDEADBEEF; return to IDLE.
- STR: `in_result`=0x10, `in_store_data`=5; ack on the first request cycle → `mem_we`=1, `mem_wdata`=5; `mem_req` high for exactly 1 cycle; no `rf_we`; flags unchanged.
- Assert `rst_n`=0 during MEM_RD, then raise `mem_ack` after reset → all outputs at reset values, `mem_req` stays 0, no write.
- Preload `retire_count` to 0xFFFFFFFF via 2^32-1 NOPs (or a force), then accept one NOP → `retire_count`=0.
